// File: rtl/io_bus_fabric.sv
// rtl/io_bus_fabric.sv - CPU data-bus fabric: RAM, slot-indexed peripherals, error register
// Optional ack timeout enabled by defining IO_BUS_FABRIC_TIMEOUT_EN.
module io_bus_fabric #(
    parameter int          NUM_SLOTS      = 8,
    parameter int          SLOT_BITS      = 4,
    parameter logic [15:0] IO_BASE        = 16'h1000,
    parameter logic [15:0] RAM_TOP        = 16'h07FF,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            address,
    input  logic [7:0]             din,
    input  logic                   w_en,
    input  logic                   r_en,
    output logic [7:0]             dout,
    output logic                   ready,
    output logic                   bus_err,
    output logic [10:0]            ram_addr,
    output logic                   ram_w_en,
    output logic                   ram_r_en,
    input  logic [7:0]             ram_dout,
    output logic [SLOT_BITS-1:0]   slot_addr,
    output logic [7:0]             slot_din,
    output logic [NUM_SLOTS-1:0]   slot_sel,
    output logic                   slot_w_en,
    output logic                   slot_r_en,
    input  logic [8*NUM_SLOTS-1:0] slot_dout,
    input  logic [NUM_SLOTS-1:0]   slot_ack
);

    localparam logic [15:0] ERR_ADDR = IO_BASE + 16'h00FF;

    typedef enum logic [1:0] {IDLE, RAM_RESP, IO_WAIT, RESP} state_e;

    state_e                 state_q;
    logic [7:0]             rdata_q;
    logic                   unmapped_q;
    logic                   timeout_q;
    logic [NUM_SLOTS-1:0]   sel_q;
    logic                   slot_w_en_q;
    logic                   slot_r_en_q;
    logic [SLOT_BITS-1:0]   slot_addr_q;
    logic [7:0]             slot_din_q;

    logic [15:0]            io_off;
    logic [15:0]            slot_idx;
    logic                   hit_ram;
    logic                   hit_err;
    logic                   hit_slot;
    logic [NUM_SLOTS-1:0]   sel_d;
    logic                   ack_hit;
    logic [7:0]             ack_data;

    assign io_off   = address - IO_BASE;
    assign slot_idx = io_off >> SLOT_BITS;
    assign hit_ram  = (address <= RAM_TOP);
    assign hit_err  = (address == ERR_ADDR);
    assign hit_slot = (address >= IO_BASE) && (slot_idx < 16'(NUM_SLOTS)) && !hit_err;

    // Acks and data from slots other than the latched one are masked off.
    always_comb begin
        sel_d    = '0;
        ack_data = 8'h00;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            sel_d[k] = (slot_idx == 16'(k));
            if (sel_q[k]) begin
                ack_data = ack_data | slot_dout[8*k +: 8];
            end
        end
    end

    assign ack_hit = |(slot_ack & sel_q);

    assign ram_addr  = address[10:0];
    assign ram_w_en  = rst && (state_q == IDLE) && hit_ram && w_en;
    assign ram_r_en  = rst && (state_q == IDLE) && hit_ram && r_en && !w_en;
    assign slot_addr = slot_addr_q;
    assign slot_din  = slot_din_q;
    assign slot_sel  = sel_q;
    assign slot_w_en = slot_w_en_q;
    assign slot_r_en = slot_r_en_q;
    assign ready     = (state_q == RAM_RESP) || (state_q == RESP);
    assign bus_err   = unmapped_q | timeout_q;

    always_comb begin
        dout = 8'h00;
        case (state_q)
            RAM_RESP: dout = ram_dout;
            RESP:     dout = rdata_q;
            default:  dout = 8'h00;
        endcase
    end

`ifdef IO_BUS_FABRIC_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rdata_q     <= 8'h00;
            unmapped_q  <= 1'b0;
            timeout_q   <= 1'b0;
            sel_q       <= '0;
            slot_w_en_q <= 1'b0;
            slot_r_en_q <= 1'b0;
            slot_addr_q <= '0;
            slot_din_q  <= 8'h00;
`ifdef IO_BUS_FABRIC_TIMEOUT_EN
            tmo_cnt_q   <= 8'd0;
`endif
        end else begin
            slot_w_en_q <= 1'b0;
            slot_r_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_en || r_en) begin
                        if (hit_ram) begin
                            state_q <= RAM_RESP;
                        end else if (hit_err) begin
                            if (w_en) begin
                                unmapped_q <= 1'b0;
                                timeout_q  <= 1'b0;
                            end else begin
                                rdata_q <= {6'b0, timeout_q, unmapped_q};
                            end
                            state_q <= RESP;
                        end else if (hit_slot) begin
                            sel_q       <= sel_d;
                            slot_w_en_q <= w_en;
                            slot_r_en_q <= !w_en;
                            slot_addr_q <= io_off[SLOT_BITS-1:0];
                            slot_din_q  <= din;
`ifdef IO_BUS_FABRIC_TIMEOUT_EN
                            tmo_cnt_q   <= 8'd0;
`endif
                            state_q     <= IO_WAIT;
                        end else begin
                            unmapped_q <= 1'b1;
                            rdata_q    <= 8'h00;
                            state_q    <= RESP;
                        end
                    end
                end
                IO_WAIT: begin
                    // An ack arriving on the final counted cycle still beats the timeout.
                    if (ack_hit) begin
                        rdata_q <= ack_data;
                        sel_q   <= '0;
                        state_q <= RESP;
                    end
`ifdef IO_BUS_FABRIC_TIMEOUT_EN
                    else if (tmo_cnt_q + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                        timeout_q <= 1'b1;
                        rdata_q   <= 8'hFF;
                        sel_q     <= '0;
                        state_q   <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                RAM_RESP: state_q <= IDLE;
                RESP:     state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_fabric.sv
// tb/tb_io_bus_fabric.sv - scoreboard bench for io_bus_fabric
module tb_io_bus_fabric;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        w_en = 1'b0;
    logic        r_en = 1'b0;
    logic [7:0]  dout;
    logic        ready;
    logic        bus_err;
    logic [10:0] ram_addr;
    logic        ram_w_en;
    logic        ram_r_en;
    logic [7:0]  ram_dout = 8'h00;
    logic [3:0]  slot_addr;
    logic [7:0]  slot_din;
    logic [7:0]  slot_sel;
    logic        slot_w_en;
    logic        slot_r_en;
    logic [63:0] slot_dout;
    logic [7:0]  slot_ack = 8'h00;

    io_bus_fabric dut (
        .clk(clk), .rst(rst), .address(address), .din(din), .w_en(w_en), .r_en(r_en),
        .dout(dout), .ready(ready), .bus_err(bus_err),
        .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_dout(ram_dout),
        .slot_addr(slot_addr), .slot_din(slot_din), .slot_sel(slot_sel),
        .slot_w_en(slot_w_en), .slot_r_en(slot_r_en), .slot_dout(slot_dout), .slot_ack(slot_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passes = 0;
    int cyc = 0;
    int req_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // RAM model: one-cycle synchronous read, writes take CPU data directly.
    logic [7:0] mem [0:2047];
    initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_addr] <= din;
        if (ram_r_en) ram_dout <= mem[ram_addr];
    end

    initial begin
        for (int k = 0; k < 8; k++) slot_dout[8*k +: 8] = 8'h10 + 8'(k);
        slot_dout[23:16] = 8'h5C;
    end

    typedef struct {
        logic [7:0] dout;
        bit         chk_d;
        int         lat;
        string      name;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (rst && ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected ready", 32'(ready), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk_d) chk({e.name, " dout"}, 32'(dout), 32'(e.dout));
                chk({e.name, " latency"}, 32'(cyc - req_cyc), 32'(e.lat));
            end
        end
    end

    // Slot responder: checks the strobe, optionally injects a spurious slot-0 ack, acks after resp_delay.
    int         resp_delay = 0;
    bit         resp_en = 1'b0;
    bit         resp_spur = 1'b0;
    logic [7:0] exp_sel = 8'h00;
    logic [3:0] exp_saddr = 4'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst && (slot_r_en || slot_w_en)) begin
                int last;
                chk("slot_sel", 32'(slot_sel), 32'(exp_sel));
                chk("slot_addr", 32'(slot_addr), 32'(exp_saddr));
                last = (resp_en && resp_delay > 1) ? resp_delay : 1;
                for (int d = 0; d <= last; d++) begin
                    if (d == 1) chk("strobe single cycle", 32'(slot_r_en | slot_w_en), 32'd0);
                    slot_ack = 8'h00;
                    if (resp_spur && d == 0) slot_ack = 8'h01;
                    if (resp_en && d == resp_delay) slot_ack = exp_sel;
                    @(negedge clk);
                end
                slot_ack = 8'h00;
            end
        end
    end

    task automatic access(input logic [15:0] a, input bit wr, input logic [7:0] wd,
                          input logic [7:0] exp_d, input bit chk_d, input int lat,
                          input bit exp_rw, input bit exp_rr, input string nm);
        exp_t e;
        bit got;
        e.dout = exp_d; e.chk_d = chk_d; e.lat = lat; e.name = nm;
        exp_q.push_back(e);
        address = a; din = wd; w_en = wr; r_en = !wr; req_cyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk({nm, " ram_w_en"}, 32'(ram_w_en), 32'(exp_rw));
                chk({nm, " ram_r_en"}, 32'(ram_r_en), 32'(exp_rr));
            end
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk({nm, " ready within bound"}, 32'(got), 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset dout", 32'(dout), 32'd0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        chk("reset slot_sel", 32'(slot_sel), 32'd0);
        chk("reset strobes", 32'({slot_w_en, slot_r_en, ram_w_en, ram_r_en}), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        access(16'h0010, 1'b1, 8'hA5, 8'h00, 1'b0, 1, 1'b1, 1'b0, "ram write 0010");
        access(16'h0010, 1'b0, 8'h00, 8'hA5, 1'b1, 1, 1'b0, 1'b1, "ram read 0010");
        access(16'h07FF, 1'b1, 8'h5A, 8'h00, 1'b0, 1, 1'b1, 1'b0, "ram write top");
        access(16'h07FF, 1'b0, 8'h00, 8'h5A, 1'b1, 1, 1'b0, 1'b1, "ram read top");

        resp_en = 1'b1; resp_spur = 1'b0;
        resp_delay = 3; exp_sel = 8'b0000_0100; exp_saddr = 4'h3;
        access(16'h1023, 1'b0, 8'h00, 8'h5C, 1'b1, 5, 1'b0, 1'b0, "slot2 read");
        resp_delay = 0; exp_sel = 8'b1000_0000; exp_saddr = 4'hA;
        access(16'h107A, 1'b1, 8'h3C, 8'h00, 1'b0, 2, 1'b0, 1'b0, "slot7 write ack0");

        access(16'h3000, 1'b0, 8'h00, 8'h00, 1'b1, 1, 1'b0, 1'b0, "unmapped 3000");
        chk("bus_err after unmapped", 32'(bus_err), 32'd1);
        access(16'h1080, 1'b0, 8'h00, 8'h00, 1'b1, 1, 1'b0, 1'b0, "unmapped past slots");
        access(16'h0800, 1'b1, 8'h77, 8'h00, 1'b0, 1, 1'b0, 1'b0, "unmapped past ram");
        access(16'h10FF, 1'b0, 8'h00, 8'h01, 1'b1, 1, 1'b0, 1'b0, "errreg read unmapped");
        access(16'h10FF, 1'b1, 8'h00, 8'h00, 1'b0, 1, 1'b0, 1'b0, "errreg clear");
        chk("bus_err after clear", 32'(bus_err), 32'd0);
        access(16'h10FF, 1'b0, 8'h00, 8'h00, 1'b1, 1, 1'b0, 1'b0, "errreg read cleared");

`ifdef IO_BUS_FABRIC_TIMEOUT_EN
        resp_en = 1'b0; exp_sel = 8'b0000_0001; exp_saddr = 4'h0;
        access(16'h1000, 1'b0, 8'h00, 8'hFF, 1'b1, 16, 1'b0, 1'b0, "slot0 timeout");
        chk("bus_err after timeout", 32'(bus_err), 32'd1);
        chk("slot_sel dropped after timeout", 32'(slot_sel), 32'd0);
        access(16'h10FF, 1'b0, 8'h00, 8'h02, 1'b1, 1, 1'b0, 1'b0, "errreg read timeout");
        access(16'h10FF, 1'b1, 8'h00, 8'h00, 1'b0, 1, 1'b0, 1'b0, "errreg clear timeout");
`endif

        resp_en = 1'b1; resp_spur = 1'b1;
        resp_delay = 2; exp_sel = 8'b0000_0010; exp_saddr = 4'h5;
        access(16'h1015, 1'b0, 8'h00, 8'h11, 1'b1, 4, 1'b0, 1'b0, "slot1 with spurious ack");
        resp_spur = 1'b0;

        resp_en = 1'b0; exp_sel = 8'b0000_1000; exp_saddr = 4'h2;
        address = 16'h1032; r_en = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset ready", 32'(ready), 32'd0);
        chk("midreset dout", 32'(dout), 32'd0);
        chk("midreset bus_err", 32'(bus_err), 32'd0);
        chk("midreset slot_sel", 32'(slot_sel), 32'd0);
        chk("midreset strobes", 32'({slot_w_en, slot_r_en, ram_w_en, ram_r_en}), 32'd0);
        r_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no ready in reset", 32'(ready), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(16'h0010, 1'b0, 8'h00, 8'hA5, 1'b1, 1, 1'b0, 1'b1, "ram read after reset");

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/io_bus_fabric.md
# io_bus_fabric

Parametrised data-bus fabric between the CPU data port and the data RAM plus a configurable array of memory-mapped peripheral slots. Replaces fixed-window decode and OR-ed read data with a registered, slot-indexed read mux, a per-slot ack handshake for multi-cycle peripherals, an optional ack timeout, and a sticky bus-error register. Sits directly behind the CPU load/store unit; peripherals (gpio, uart, counter_timer, etc.) attach to slot ports.

## Interface
Parameters:
- NUM_SLOTS, 8: number of peripheral slots (1–16).
- SLOT_BITS, 4: register-address bits per slot; slot window = 2^SLOT_BITS bytes. NUM_SLOTS·2^SLOT_BITS ≤ 255.
- IO_BASE, 16'h1000: base of I/O region; slot k spans IO_BASE + k·2^SLOT_BITS.
- RAM_TOP, 16'h07FF: RAM occupies 16'h0000–RAM_TOP.
- TIMEOUT_CYCLES, 15: max cycles waiting for slot ack (1–255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- address  input  16  CPU byte address.
- din  input  8  CPU write data.
- w_en  input  1  CPU write request.
- r_en  input  1  CPU read request.
- dout  output  8  read data, valid when ready=1.
- ready  output  1  one-cycle transaction-complete pulse.
- bus_err  output  1  OR of sticky error flags.
- ram_addr  output  11  address[10:0].
- ram_w_en / ram_r_en  output  1 each  RAM strobes.
- ram_dout  input  8  RAM read data (one-cycle synchronous).
- slot_addr  output  SLOT_BITS  register offset within slot.
- slot_din  output  8  broadcast write data.
- slot_sel  output  NUM_SLOTS  one-hot selected slot.
- slot_w_en / slot_r_en  output  1 each  one-cycle access strobes.
- slot_dout  input  8·NUM_SLOTS  slot k data in bits [8k+7:8k].
- slot_ack  input  NUM_SLOTS  per-slot completion.

## Operation
- States: IDLE, RAM_RESP, IO_WAIT, RESP.
- CPU holds address/din/w_en/r_en stable from request until ready=1. w_en and r_en both high: treated as write.
- Decode in IDLE: RAM range → ram_*_en asserted that cycle, next state RAM_RESP. Slot index k = (address−IO_BASE)>>SLOT_BITS < NUM_SLOTS → slot_sel[k], slot_*_en asserted for exactly one cycle, next IO_WAIT. ERR_ADDR = IO_BASE+16'h00FF → internal register, next RESP. Anything else → unmapped: unmapped_flag set, rdata=8'h00, next RESP; no strobes.
- RAM_RESP: ready=1, dout=ram_dout, return IDLE.
- IO_WAIT: slot_sel held, strobes low. slot_ack[k]=1 → rdata ← slot_dout[k], next RESP. Acks from unselected slots ignored.
- RESP: ready=1, dout=rdata, return IDLE.
- Error register at ERR_ADDR: read returns {6'b0, timeout_flag, unmapped_flag}; any write clears both. Flags set in the same cycle as a clear: set wins.

## Timing
- Reset (asynchronous, rst=0): state IDLE; dout=0, ready=0, bus_err=0, all strobes and slot_sel=0, flags cleared, timeout counter 0. Mid-transaction reset drops strobes immediately; no ready issued.
- RAM access: request cycle N, ready at N+1 (2-cycle transaction).
- IO access with ack at strobe cycle +d (d≥0; ack in strobe cycle allowed): ready at N+d+2.
- Internal/unmapped access: ready at N+1.
- Back-to-back: new request sampled in IDLE the cycle after ready.
- Timeout counter (8-bit) clears on IO_WAIT entry, increments each IO_WAIT cycle.

## Configuration
- IO_BUS_FABRIC_TIMEOUT_EN defined: if counter reaches TIMEOUT_CYCLES without ack, timeout_flag set, rdata=8'hFF, next RESP, slot_sel dropped. Ack and timeout in the same cycle: ack wins, no flag.
- Undefined: no counter; IO_WAIT waits indefinitely; timeout_flag reads 0.

## Test plan
- Write 8'hA5 to 16'h0010, read back → ram_w_en pulse, ready at N+1; read dout=8'hA5 at N+1.
- Read slot 2 offset 3 (16'h1023), ack 3 cycles after strobe, slot_dout[23:16]=8'h5C → slot_sel=8'b00000100, slot_addr=3, single-cycle slot_r_en, ready at N+5 with dout=8'h5C.
- Read 16'h3000 → ready at N+1, dout=8'h00, bus_err=1; read 16'h10FF → 8'h01; write 16'h10FF → bus_err=0.
- TIMEOUT_EN, TIMEOUT_CYCLES=15, slot 0 never acks → ready with dout=8'hFF, bus_err=1, error register reads 8'h02.
- Slot 1 selected, slot 0 acks spuriously then slot 1 acks → only slot 1 data returned; assert rst=0 during a later IO_WAIT → ready never pulses, all outputs 0 asynchronously.
